// File: rtl/regfile_seq_ctrl_if.sv
// Command/response handshake plus the regfile port bundle of regfile_seq_ctrl.
// The slave modport is the sequencer; the master modport is its environment
// (datapath control issuing commands and the register file returning read data).
interface regfile_seq_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [DW-1:0] cmd_imm;
  logic          done;
  logic          err;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rf_w;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] rf_raA;
  logic [AW-1:0] rf_raB;
  logic [DW-1:0] rf_rdA;
  logic [DW-1:0] rf_rdB;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rf_rdA, rf_rdB,
    input  cmd_ready, done, err, rsp_valid, rsp_data,
           rf_w, rf_wa, rf_wd, rf_raA, rf_raB
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rf_rdA, rf_rdB,
    output cmd_ready, done, err, rsp_valid, rsp_data,
           rf_w, rf_wa, rf_wd, rf_raA, rf_raB
  );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for regfile_4x16: turns WRITE/READ/COPY/SWAP commands into
// timed read-address setup, read-data capture and one or two register writes.
// Every output is decoded from the state register and latched command fields,
// so nothing on the command inputs reaches an output combinationally.
module regfile_seq_ctrl #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR1, WR2, DONE} state_t;

  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam logic [1:0]  OP_COPY  = 2'b10;
  localparam logic [1:0]  OP_SWAP  = 2'b11;
  localparam logic [31:0] NREG_U   = 32'(NREG);

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    op_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] imm_q;
  logic          bad_q;
  logic [DW-1:0] lat_a;
  logic [DW-1:0] lat_b;
  logic [DW-1:0] rsp_q;
  logic          accept;
  logic          cmd_bad;

  assign accept = (state == IDLE) && bus.cmd_valid;

  // Flag an incoming command that names an out-of-range register in a field it actually uses
  always_comb begin
    cmd_bad = 1'b0;
    if ((bus.cmd_op != OP_WRITE) && (32'(bus.cmd_src) >= NREG_U)) cmd_bad = 1'b1;
    if ((bus.cmd_op != OP_READ)  && (32'(bus.cmd_dst) >= NREG_U)) cmd_bad = 1'b1;
  end

  // State register; reset abandons any command in flight and drops rf_w at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing for each command type
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_bad)                     state_nxt = DONE;
          else if (bus.cmd_op == OP_WRITE) state_nxt = WR1;
          else                             state_nxt = RD;
        end
      end
      RD:      state_nxt = (op_q == OP_READ) ? DONE : WR1;
      WR1:     state_nxt = (op_q == OP_SWAP) ? WR2 : DONE;
      WR2:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the command at accept and capture both read ports at the end of RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      bad_q <= 1'b0;
      lat_a <= '0;
      lat_b <= '0;
      rsp_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        src_q <= bus.cmd_src;
        dst_q <= bus.cmd_dst;
        imm_q <= bus.cmd_imm;
        bad_q <= cmd_bad;
      end
      if (state == RD) begin
        lat_a <= bus.rf_rdA;
        lat_b <= bus.rf_rdB;
        if (op_q == OP_READ) rsp_q <= bus.rf_rdA;
      end
    end
  end

  // Decode regfile pins and status pulses from state and latched fields
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.rf_raA    = src_q;
    bus.rf_raB    = dst_q;
    bus.rf_w      = (state == WR1) || (state == WR2);
    bus.rf_wa     = (state == WR2) ? src_q : dst_q;
    if (state == WR2)         bus.rf_wd = lat_b;
    else if (op_q == OP_WRITE) bus.rf_wd = imm_q;
    else                       bus.rf_wd = lat_a;
    bus.done      = (state == DONE);
    bus.err       = (state == DONE) && bad_q;
    bus.rsp_valid = (state == DONE) && !bad_q && (op_q == OP_READ);
    bus.rsp_data  = rsp_q;
  end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Command sequencer that drives the write and two read ports of regfile_4x16. It accepts register-level commands (write immediate, read, copy, swap) over a valid/ready handshake. It converts each command into timed regfile port activity: raA/raB set-up, read-data capture, then one or two synchronous writes. It sits between the datapath control and the register file and owns the regfile's wa/w/wd/raA/raB pins.

Parameters:
DW, 16, data word width (matches regfile wd/rdA/rdB)
AW, 3, register address width (matches regfile wa/raA/raB)
NREG, 4, number of implemented registers; addresses >= NREG are illegal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 WRITE, 01 READ, 10 COPY, 11 SWAP
cmd_src  in  AW  source register (READ/COPY/SWAP)
cmd_dst  in  AW  destination register (WRITE/COPY/SWAP)
cmd_imm  in  DW  immediate data (WRITE only)
done  out  1  one-cycle pulse when command completes
err  out  1  one-cycle pulse, coincident with done, for an illegal address
rsp_valid  out  1  one-cycle pulse with done for a legal READ
rsp_data  out  DW  READ result, held until the next READ completes
rf_w  out  1  regfile write enable
rf_wa  out  AW  regfile write address
rf_wd  out  DW  regfile write data
rf_raA  out  AW  regfile read address A
rf_raB  out  AW  regfile read address B
rf_rdA  in  DW  regfile read data A (combinational from rf_raA)
rf_rdB  in  DW  regfile read data B (combinational from rf_raB)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rf_w=0; rf_wa=rf_raA=rf_raB=0; rf_wd=0; done=err=rsp_valid=0; rsp_data=0; latched cmd fields=0. cmd_ready=1 from the first cycle after release.
- States: IDLE, RD, WR1, WR2, DONE. cmd_ready=1 only in IDLE.
- All rf_* outputs and status outputs derive from the state register and latched command fields only. There is no combinational path from cmd_* inputs to outputs.
- Accept edge: in IDLE with cmd_valid=1, the controller latches op/src/dst/imm. Transitions:
  - WRITE: IDLE -> WR1 -> DONE -> IDLE.
  - READ: IDLE -> RD -> DONE -> IDLE.
  - COPY: IDLE -> RD -> WR1 -> DONE -> IDLE.
  - SWAP: IDLE -> RD -> WR1 -> WR2 -> DONE -> IDLE.
  - Illegal address on any used field (src for READ/COPY/SWAP, dst for WRITE/COPY/SWAP, value >= NREG): IDLE -> DONE with err=1. No rf_w assertion. Unused fields are not checked.
- RD: rf_raA=src, rf_raB=dst, rf_w=0. At the end-of-cycle edge, rdA is captured into latch A and rdB into latch B. For READ, rsp_data<=rdA at the same edge.
- WR1: rf_w=1, rf_wa=dst. rf_wd=imm for WRITE, latch A for COPY/SWAP.
- WR2 (SWAP only): rf_w=1, rf_wa=src, rf_wd=latch B.
- DONE: done=1, rf_w=0. rsp_valid=1 if op was a legal READ. err as above.
- Outside WR1/WR2, rf_w=0. rf_wa/rf_wd/rf_raA/rf_raB may hold their last values.
- Cycles from accept edge to done pulse: WRITE 2, READ 2, COPY 3, SWAP 4, illegal 1. A new command can be accepted on the edge after DONE.
- SWAP with src==dst: runs the full sequence; the register value is unchanged. COPY with src==dst: rewrites the same value.
- cmd_valid held high while cmd_ready=0 is ignored. The command is accepted only on return to IDLE, using the input values present at that edge.
- rst_n asserted mid-command: rf_w drops immediately and the command is abandoned. A SWAP reset between WR1 and WR2 leaves dst updated and src unchanged; this is accepted behaviour.

Test Plan:
- WRITE dst=0 imm=16'hAAAA, then WRITE dst=1 imm=16'h5555 -> each done 2 cycles after accept; rf_w high exactly one cycle per command; READ src=0 returns rsp_data=16'hAAAA with rsp_valid.
- COPY src=0 dst=3 after the above -> done 3 cycles after accept; READ src=3 returns 16'hAAAA; reg 0 unchanged.
- SWAP src=0 dst=1 (regs hold AAAA/5555) -> done 4 cycles after accept; two consecutive rf_w cycles (wa=1 wd=AAAA, then wa=0 wd=5555); READs return reg0=5555, reg1=AAAA.
- WRITE dst=5 imm=16'h1234 -> done and err pulse 1 cycle after accept; rf_w never asserted; all four registers unchanged. READ src=4 -> err=1, rsp_valid=0, rsp_data keeps its prior value.
- Back-to-back cmd_valid held high with four commands -> each accepted only when cmd_ready=1; no command dropped or duplicated; done count equals 4.
- Reset pulse during SWAP WR1 -> outputs return to reset values asynchronously; reg dst updated, reg src unchanged; cmd_ready=1 after release; the next WRITE completes normally.
